// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg -- ID/EX pipeline register with load-use hazard detection.
//
// Latches the main decoder's control word together with the decoded operands,
// register indices, funct and PC+4, and presents them to EX one cycle later.
// A load in EX whose destination (rt) is read by the instruction in ID raises
// hazard_stall, which holds IF/ID and the PC and turns the next EX slot into a
// bubble. A downstream stall holds the whole register. A flush from a branch
// or jump also produces a bubble. stall takes priority over flush and hazard.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   stall                 hold every field, including valid
//   flush                 next EX content is a bubble
//   id_*                  decoder controls and ID data fields
//   ex_*                  registered copies presented to EX
//   hazard_stall          combinational load-use hold request for IF/ID and PC
//   bubble_count          saturating count of inserted bubbles
//                         (present only when ID_EX_PERF_CNT_EN is defined)
//
// Build option: define ID_EX_PERF_CNT_EN to add the bubble_count output.

module id_ex_stage_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic                  id_reg_dst,
  input  logic                  id_alu_src,
  input  logic                  id_mem_to_reg,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_branch,
  input  logic                  id_jump,
  input  logic [ALUOP_W-1:0]    id_alu_op,
  input  logic [DATA_W-1:0]     id_pc_plus4,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm_ext,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [5:0]            id_funct,
  output logic                  ex_valid,
  output logic                  ex_reg_dst,
  output logic                  ex_alu_src,
  output logic                  ex_mem_to_reg,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic [DATA_W-1:0]     ex_pc_plus4,
  output logic [DATA_W-1:0]     ex_rs_data,
  output logic [DATA_W-1:0]     ex_rt_data,
  output logic [DATA_W-1:0]     ex_imm_ext,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [5:0]            ex_funct,
  output logic                  hazard_stall
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      bubble_count
`endif
);

  logic id_uses_rt;
  logic bubble;

  // rt is a source for R-type (reg_dst), stores (store data) and branches.
  always_comb begin
    id_uses_rt   = id_reg_dst | id_mem_write | id_branch;
    hazard_stall = id_valid & ex_valid & ex_mem_read & (ex_rt != '0) &
                   ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    bubble       = flush | hazard_stall;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid      <= 1'b0;
      ex_reg_dst    <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_jump       <= 1'b0;
      ex_alu_op     <= '0;
      ex_pc_plus4   <= '0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm_ext    <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      ex_funct      <= '0;
    end else if (!stall) begin
      if (bubble) begin
        // Bubble: kill valid and every control; data fields keep old values.
        ex_valid      <= 1'b0;
        ex_reg_dst    <= 1'b0;
        ex_alu_src    <= 1'b0;
        ex_mem_to_reg <= 1'b0;
        ex_reg_write  <= 1'b0;
        ex_mem_read   <= 1'b0;
        ex_mem_write  <= 1'b0;
        ex_branch     <= 1'b0;
        ex_jump       <= 1'b0;
        ex_alu_op     <= '0;
      end else begin
        ex_valid      <= id_valid;
        ex_reg_dst    <= id_reg_dst;
        ex_alu_src    <= id_alu_src;
        ex_mem_to_reg <= id_mem_to_reg;
        ex_reg_write  <= id_reg_write;
        ex_mem_read   <= id_mem_read;
        ex_mem_write  <= id_mem_write;
        ex_branch     <= id_branch;
        ex_jump       <= id_jump;
        ex_alu_op     <= id_alu_op;
        ex_pc_plus4   <= id_pc_plus4;
        ex_rs_data    <= id_rs_data;
        ex_rt_data    <= id_rt_data;
        ex_imm_ext    <= id_imm_ext;
        ex_rs         <= id_rs;
        ex_rt         <= id_rt;
        ex_rd         <= id_rd;
        ex_funct      <= id_funct;
      end
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_count <= '0;
    end else if (!stall && bubble && (bubble_count != '1)) begin
      bubble_count <= bubble_count + 1'b1;
    end
  end
`endif

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register directly downstream of the main control decoder. Latches the decoder's control word with the decoded operands, register indices, funct and PC+4, and presents them to EX one cycle later.
- Owns load-use hazard detection. Inserts a bubble into EX and tells IF/ID to hold.
- Honours a downstream stall (hold) and a branch/jump flush (bubble).

Parameters:
- DATA_W, 32, width of operand, immediate and PC fields
- REG_ADDR_W, 5, register index width
- ALUOP_W, 3, aluOp width; encoding as decoder: 000 add, 001 sub, 010 R-type, 011 and, 100 or, 101 slt, 111 bne
- CNT_W, 16, bubble counter width (optional feature only)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  downstream hold request; register keeps contents
- flush  in  1  branch/jump redirect; next EX content is a bubble
- id_valid  in  1  ID slot holds a real instruction
- id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump  in  1 each  decoder control bits
- id_alu_op  in  ALUOP_W  decoder aluOp
- id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext  in  DATA_W each  ID data fields
- id_rs, id_rt, id_rd  in  REG_ADDR_W each  register indices
- id_funct  in  6  instruction[5:0]
- ex_valid, ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump  out  1 each  registered controls
- ex_alu_op  out  ALUOP_W;  ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext  out  DATA_W;  ex_rs, ex_rt, ex_rd  out  REG_ADDR_W;  ex_funct  out  6
- hazard_stall  out  1  combinational; IF/ID and PC must hold this cycle

Behaviour:
- Reset: all ex_* outputs are 0. hazard_stall is 0 because ex_valid=0.
- Latency: 1 cycle ID→EX on a normal load.
- id_uses_rt = id_reg_dst | id_mem_write | id_branch.
- hazard_stall = id_valid & ex_valid & ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
- Per-edge priority:
  1. reset → all zero.
  2. stall → hold every field, including valid.
  3. flush or hazard_stall → bubble: ex_valid and all control outputs (including ex_alu_op) set to 0; data/index/funct fields hold their old values.
  4. Otherwise load all id_* fields.
- stall and flush in the same cycle: stall wins. flush must be re-asserted by the requester while stalled.
- A bubble (ex_valid=0, ex_mem_read=0) never raises hazard_stall. Back-to-back load-use therefore costs exactly one bubble.
- id_valid=0 with no other event: fields load normally. ex_valid follows as 0; controls are loaded as given and must already be 0 from upstream.
- Reset mid-stall or mid-hazard clears everything; no pending state is kept.
- No other state exists besides the optional counter.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- Defined: adds output bubble_count [CNT_W-1:0].
  - Increments by 1 on each edge where a bubble is inserted (flush or hazard_stall, and not stall).
  - Saturates at all-ones; cleared by reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: reset=1 for 2 cycles with random id_* → all ex_* = 0, hazard_stall = 0.
- Normal flow: lw (mem_read=1, alu_src=1, alu_op=000, rt=8) → next cycle ex_mem_read=1, ex_rt=8, ex_valid=1. Then add with rs=8 in ID → hazard_stall=1; next edge ex_valid=0, all controls 0. Following cycle the add loads, ex_reg_dst=1, ex_alu_op=010.
- ex_rt=0 load followed by an rs=0 consumer → hazard_stall stays 0. sw with id_rt=ex_rt=5 after a lw → hazard_stall=1.
- stall=1 for 3 cycles with changing id_* → ex_* constant. Then flush=1 with stall=0 → bubble next edge.
- stall=1 and flush=1 together → hold. bubble_count (feature on) does not increment.
- Feature on: 0xFFFF + 2 bubbles → bubble_count stays 0xFFFF. Reset → 0.
